// File: rtl/otter_pkg.sv
// ---------------------------------------------------------------------------
// otter_pkg
// Shared definitions for the OTTER RV32I control path.
//   opcode_t   : RV32I major opcodes (ir[6:0]); the opcode decoder uses it too.
//   cu_state_t : sequencer states INIT, FETCH, EXEC, WB, INTR.
//   F_MRET / F_CSRRW : ir[14:12] values that select the two SYSTEM forms
//                      the sequencer treats specially.
// ---------------------------------------------------------------------------
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_t;

    localparam logic [2:0] F_MRET  = 3'b000;
    localparam logic [2:0] F_CSRRW = 3'b001;

endpackage

// File: rtl/cu_fsm.sv
// ---------------------------------------------------------------------------
// cu_fsm
// Multicycle sequencer for the OTTER RV32I core. Steps every instruction
// through FETCH / EXEC (/ WB for loads), raises the datapath strobes, and
// takes pending interrupts between instructions via the INTR state.
//
// Build option: CU_MEM_WAIT_EN
//   defined   : MEM_READY port exists; FETCH and WB hold until MEM_READY=1.
//   undefined : no MEM_READY port; FETCH and WB last exactly one cycle.
//
// Parameters
//   INIT_CYCLES : cycles spent in INIT with RST_OUT high after reset (>=1)
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   INTR       in   level interrupt request
//   CSR_MIE    in   machine interrupt enable from the CSR file
//   CU_OPCODE  in   ir[6:0]
//   FUNC       in   ir[14:12]
//   MEM_READY  in   memory done (CU_MEM_WAIT_EN builds only)
//   RST_OUT    out  reset to PC / datapath
//   PC_WRITE   out  PC load enable
//   REG_WRITE  out  register file write enable
//   MEM_WE2    out  data memory write strobe
//   MEM_RDEN1  out  instruction memory read enable
//   MEM_RDEN2  out  data memory read enable
//   CSR_WE     out  CSR write enable (csrrw)
//   MRET_EXEC  out  mret executing; CSR file restores MIE
//   INT_TAKEN  out  interrupt entry cycle; decoder selects the trap PC
// ---------------------------------------------------------------------------
module cu_fsm
    import otter_pkg::*;
#(
    parameter int INIT_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INTR,
    input  logic       CSR_MIE,
    input  logic [6:0] CU_OPCODE,
    input  logic [2:0] FUNC,
`ifdef CU_MEM_WAIT_EN
    input  logic       MEM_READY,
`endif
    output logic       RST_OUT,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_WE2,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       CSR_WE,
    output logic       MRET_EXEC,
    output logic       INT_TAKEN
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(INIT_CYCLES - 1);

    cu_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;

    cu_state_t        w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_take_int;

    logic w_rst_out, w_pc_write, w_reg_write, w_mem_we2, w_mem_rden1;
    logic w_mem_rden2, w_csr_we, w_mret_exec, w_int_taken;

    // Interrupt request is sampled only in the cycle an instruction retires.
    assign w_take_int = INTR & CSR_MIE;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rst_out    = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_we2    = 1'b0;
        w_mem_rden1  = 1'b0;
        w_mem_rden2  = 1'b0;
        w_csr_we     = 1'b0;
        w_mret_exec  = 1'b0;
        w_int_taken  = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_rst_out = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = ST_FETCH;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end

            ST_FETCH: begin
                w_mem_rden1 = 1'b1;
`ifdef CU_MEM_WAIT_EN
                if (MEM_READY) begin
                    w_state_next = ST_EXEC;
                end
`else
                w_state_next = ST_EXEC;
`endif
            end

            ST_EXEC: begin
                if (CU_OPCODE == OP_LOAD) begin
                    // Load completes in WB; no interrupt check here.
                    w_mem_rden2  = 1'b1;
                    w_state_next = ST_WB;
                end else begin
                    w_pc_write = 1'b1;
                    case (CU_OPCODE)
                        OP_STORE: w_mem_we2 = 1'b1;
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP:
                            w_reg_write = 1'b1;
                        OP_SYSTEM: begin
                            if (FUNC == F_CSRRW) begin
                                w_csr_we    = 1'b1;
                                w_reg_write = 1'b1;
                            end else if (FUNC == F_MRET) begin
                                w_mret_exec = 1'b1;
                            end
                        end
                        // Branch and unknown opcodes only advance the PC.
                        default: ;
                    endcase
                    // On mret, CSR_MIE is still the pre-restore value.
                    w_state_next = w_take_int ? ST_INTR : ST_FETCH;
                end
            end

            ST_WB: begin
`ifdef CU_MEM_WAIT_EN
                w_mem_rden2 = 1'b1;
                if (MEM_READY) begin
                    w_reg_write  = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = w_take_int ? ST_INTR : ST_FETCH;
                end
`else
                w_reg_write  = 1'b1;
                w_pc_write   = 1'b1;
                w_state_next = w_take_int ? ST_INTR : ST_FETCH;
`endif
            end

            ST_INTR: begin
                w_int_taken  = 1'b1;
                w_pc_write   = 1'b1;
                w_state_next = ST_FETCH;
            end

            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_INIT;
            r_cnt   <= CNT_RELOAD;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // RST overrides the decoded strobes so the datapath sees a clean reset
    // immediately, without waiting for the state flop to settle.
    assign RST_OUT   = w_rst_out | RST;
    assign PC_WRITE  = w_pc_write  & ~RST;
    assign REG_WRITE = w_reg_write & ~RST;
    assign MEM_WE2   = w_mem_we2   & ~RST;
    assign MEM_RDEN1 = w_mem_rden1 & ~RST;
    assign MEM_RDEN2 = w_mem_rden2 & ~RST;
    assign CSR_WE    = w_csr_we    & ~RST;
    assign MRET_EXEC = w_mret_exec & ~RST;
    assign INT_TAKEN = w_int_taken & ~RST;

endmodule

// File: tb/tb_cu_fsm.sv
// ---------------------------------------------------------------------------
// tb_cu_fsm
// Directed bench for cu_fsm with INIT_CYCLES=3. Inputs change 1 ns after a
// rising edge and outputs are compared there, well away from the edge.
// ---------------------------------------------------------------------------
module tb_cu_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       intr = 1'b0;
    logic       csr_mie = 1'b0;
    logic [6:0] opcode = 7'b0;
    logic [2:0] func = 3'b0;
`ifdef CU_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic rst_out, pc_write, reg_write, mem_we2, mem_rden1;
    logic mem_rden2, csr_we, mret_exec, int_taken;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cu_fsm #(.INIT_CYCLES(3)) dut (
        .CLK       (clk),
        .RST       (rst),
        .INTR      (intr),
        .CSR_MIE   (csr_mie),
        .CU_OPCODE (opcode),
        .FUNC      (func),
`ifdef CU_MEM_WAIT_EN
        .MEM_READY (mem_ready),
`endif
        .RST_OUT   (rst_out),
        .PC_WRITE  (pc_write),
        .REG_WRITE (reg_write),
        .MEM_WE2   (mem_we2),
        .MEM_RDEN1 (mem_rden1),
        .MEM_RDEN2 (mem_rden2),
        .CSR_WE    (csr_we),
        .MRET_EXEC (mret_exec),
        .INT_TAKEN (int_taken)
    );

    // Output vector order: {RST_OUT, PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1,
    //                       MEM_RDEN2, CSR_WE, MRET_EXEC, INT_TAKEN}
    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end else begin
            $display("ok   %s outs=%b", tag, got);
        end
    endtask

    function automatic logic [8:0] outs();
        return {rst_out, pc_write, reg_write, mem_we2, mem_rden1,
                mem_rden2, csr_we, mret_exec, int_taken};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_RST   = 9'b100000000;
    localparam logic [8:0] O_FETCH = 9'b000010000;
    localparam logic [8:0] O_ALU   = 9'b011000000;
    localparam logic [8:0] O_PC    = 9'b010000000;
    localparam logic [8:0] O_LDEX  = 9'b000001000;
    localparam logic [8:0] O_WB    = 9'b011000000;
    localparam logic [8:0] O_ST    = 9'b010100000;
    localparam logic [8:0] O_INT   = 9'b010000001;
    localparam logic [8:0] O_CSR   = 9'b011000100;
    localparam logic [8:0] O_MRET  = 9'b010000010;

    initial begin
        // Reset held: only RST_OUT.
        #2;
        check("reset_hold", outs(), O_RST);
        step();
        rst = 1'b0;
        #1;
        check("init_c1", outs(), O_RST);
        step();
        check("init_c2", outs(), O_RST);
        step();
        check("init_c3", outs(), O_RST);
        step();
        check("first_fetch", outs(), O_FETCH);

        // OP instruction; an interrupt raised during FETCH must not be taken there.
        opcode = 7'b0110011;
        intr = 1'b1; csr_mie = 1'b1;
        step();
        check("op_exec_no_int_in_fetch", outs(), O_ALU);
        intr = 1'b0;
        step();
        check("op_next_fetch", outs(), O_FETCH);

        // LOAD with interrupt pending in EXEC: goes to WB first, then INTR.
        opcode = 7'b0000011;
        step();
        check("load_exec", outs(), O_LDEX);
        intr = 1'b1;
`ifdef CU_MEM_WAIT_EN
        mem_ready = 1'b0;
        step();
        check("load_wb_wait1", outs(), O_LDEX);
        step();
        check("load_wb_wait2", outs(), O_LDEX);
        mem_ready = 1'b1;
        #1;
        check("load_wb_ready", outs(), O_WB | O_LDEX);
`else
        step();
        check("load_wb", outs(), O_WB);
`endif
        step();
        check("load_then_int", outs(), O_INT);
        intr = 1'b0;
        step();
        check("int_then_fetch", outs(), O_FETCH);

        // Plain LOAD, no interrupt.
        step();
        check("load2_exec", outs(), O_LDEX);
        csr_mie = 1'b0;
        step();
`ifdef CU_MEM_WAIT_EN
        check("load2_wb", outs(), O_WB | O_LDEX);
`else
        check("load2_wb", outs(), O_WB);
`endif
        step();
        check("load2_fetch", outs(), O_FETCH);

        // STORE with INTR & MIE.
        opcode = 7'b0100011;
        step();
        intr = 1'b1; csr_mie = 1'b1;
        #1;
        check("store_exec_int", outs(), O_ST);
        step();
        intr = 1'b0;
        check("store_int_taken", outs(), O_INT);
        step();
        check("store_int_fetch", outs(), O_FETCH);

        // STORE with INTR but MIE clear: no interrupt.
        intr = 1'b1; csr_mie = 1'b0;
        step();
        check("store_exec_nomie", outs(), O_ST);
        step();
        check("store_nomie_fetch", outs(), O_FETCH);
        intr = 1'b0;

        // BRANCH: PC only.
        opcode = 7'b1100011;
        step();
        check("branch_exec", outs(), O_PC);
        step();
        check("branch_fetch", outs(), O_FETCH);

        // csrrw.
        opcode = 7'b1110011; func = 3'b001;
        step();
        check("csrrw_exec", outs(), O_CSR);
        step();
        check("csrrw_fetch", outs(), O_FETCH);

        // mret with INTR & MIE: takes the interrupt next.
        func = 3'b000;
        step();
        intr = 1'b1; csr_mie = 1'b1;
        #1;
        check("mret_exec", outs(), O_MRET);
        step();
        intr = 1'b0; csr_mie = 1'b0;
        check("mret_then_int", outs(), O_INT);
        step();
        check("mret_int_fetch", outs(), O_FETCH);

        // SYSTEM with other FUNC: nop.
        func = 3'b010;
        step();
        check("system_f010_nop", outs(), O_PC);
        step();
        check("system_nop_fetch", outs(), O_FETCH);

        // Unknown opcode: nop.
        opcode = 7'b1111111;
        step();
        check("illegal_op_nop", outs(), O_PC);
        step();
        check("illegal_fetch", outs(), O_FETCH);

        // Reset pulse mid-EXEC: immediate RST_OUT, then 3 INIT cycles.
        opcode = 7'b0110011;
        step();
        check("pre_reset_exec", outs(), O_ALU);
        rst = 1'b1;
        #1;
        check("reset_async", outs(), O_RST);
        step();
        rst = 1'b0;
        #1;
        check("rst2_init_c1", outs(), O_RST);
        step();
        check("rst2_init_c2", outs(), O_RST);
        step();
        check("rst2_init_c3", outs(), O_RST);
        step();
        check("rst2_fetch", outs(), O_FETCH);
        check("none_when_idle_guard", outs() & ~O_FETCH, O_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
